// File: rtl/qnigma_sipo_frame.sv
// Frame-aware serial-in/parallel-out collector: packs WIDTH-bit words into
// LENGTH-word blocks, flushing on EOF and discarding partial blocks on SOF.
module qnigma_sipo_frame #(
  parameter int WIDTH      = 8,
  parameter int LENGTH     = 8,
  parameter int FIRST_HIGH = 1,
  localparam int CW        = $clog2(LENGTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          ser_i,
  input  logic                      ser_val_i,
  input  logic                      ser_sof_i,
  input  logic                      ser_eof_i,
  output logic [LENGTH*WIDTH-1:0]   par_o,
  output logic [CW-1:0]             par_cnt_o,
  output logic                      par_last_o,
  output logic                      par_val_o,
  input  logic                      par_rdy_i,
  output logic                      ovf_o,
  output logic                      abort_o
);

  logic [LENGTH-2:0][WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [LENGTH-1:0][WIDTH-1:0] par_q, par_d;
  logic [CW-1:0]                par_cnt_q, par_cnt_d;
  logic                         par_last_q, par_last_d;
  logic                         par_val_q, par_val_d;
  logic                         ovf_q, ovf_d;
  logic                         abort_q, abort_d;

  logic [CW-1:0]                eff_cnt;
  logic                         complete;
  logic                         out_free;
  logic [LENGTH-1:0][WIDTH-1:0] slots;
  logic [LENGTH-1:0][WIDTH-1:0] blk;

  always_comb begin
    // An SOF word restarts the block at slot 0 regardless of the fill count
    eff_cnt  = ser_sof_i ? '0 : cnt_q;
    complete = (eff_cnt == CW'(LENGTH - 1)) || ser_eof_i;
    out_free = !par_val_q || par_rdy_i;

    slots = '0;
    for (int unsigned k = 0; k < LENGTH - 1; k++) begin
      if (CW'(k) < eff_cnt) slots[k] = acc_q[k];
    end
    for (int unsigned k = 0; k < LENGTH; k++) begin
      if (CW'(k) == eff_cnt) slots[k] = ser_i;
    end

    blk = '0;
    for (int unsigned k = 0; k < LENGTH; k++) begin
      if (FIRST_HIGH != 0) blk[LENGTH-1-k] = slots[k];
      else                 blk[k]          = slots[k];
    end

    acc_d      = acc_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    par_cnt_d  = par_cnt_q;
    par_last_d = par_last_q;
    par_val_d  = par_val_q && !par_rdy_i;
    ovf_d      = ovf_q;
    abort_d    = 1'b0;

    if (ser_val_i) begin
      abort_d = ser_sof_i && (cnt_q != '0);
      if (complete) begin
        cnt_d = '0;
        if (out_free) begin
          par_d      = blk;
          par_cnt_d  = eff_cnt + CW'(1);
          par_last_d = ser_eof_i;
          par_val_d  = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        for (int unsigned k = 0; k < LENGTH - 1; k++) begin
          if (CW'(k) == eff_cnt) acc_d[k] = ser_i;
        end
        cnt_d = eff_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      par_q      <= '0;
      par_cnt_q  <= '0;
      par_last_q <= 1'b0;
      par_val_q  <= 1'b0;
      ovf_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      par_q      <= par_d;
      par_cnt_q  <= par_cnt_d;
      par_last_q <= par_last_d;
      par_val_q  <= par_val_d;
      ovf_q      <= ovf_d;
      abort_q    <= abort_d;
    end
  end

  assign par_o      = par_q;
  assign par_cnt_o  = par_cnt_q;
  assign par_last_o = par_last_q;
  assign par_val_o  = par_val_q;
  assign ovf_o      = ovf_q;
  assign abort_o    = abort_q;

endmodule

// File: tb/tb_qnigma_sipo_frame.sv
// Bench for qnigma_sipo_frame: both word orders driven from one stimulus
// table, expected blocks queued at drive time and checked on acceptance.
module tb_qnigma_sipo_frame;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int CW = $clog2(L + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   ser;
  logic           ser_val, ser_sof, ser_eof;
  logic           par_rdy;

  logic [L*W-1:0] par_h, par_l;
  logic [CW-1:0]  cnt_h, cnt_l;
  logic           last_h, last_l, val_h, val_l;
  logic           ovf_h, ovf_l, abort_h, abort_l;

  qnigma_sipo_frame #(.WIDTH(W), .LENGTH(L), .FIRST_HIGH(1)) dut_h (
    .clk(clk), .rst(rst), .ser_i(ser), .ser_val_i(ser_val),
    .ser_sof_i(ser_sof), .ser_eof_i(ser_eof), .par_o(par_h),
    .par_cnt_o(cnt_h), .par_last_o(last_h), .par_val_o(val_h),
    .par_rdy_i(par_rdy), .ovf_o(ovf_h), .abort_o(abort_h)
  );

  qnigma_sipo_frame #(.WIDTH(W), .LENGTH(L), .FIRST_HIGH(0)) dut_l (
    .clk(clk), .rst(rst), .ser_i(ser), .ser_val_i(ser_val),
    .ser_sof_i(ser_sof), .ser_eof_i(ser_eof), .par_o(par_l),
    .par_cnt_o(cnt_l), .par_last_o(last_l), .par_val_o(val_l),
    .par_rdy_i(par_rdy), .ovf_o(ovf_l), .abort_o(abort_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    bit          sof;
    bit          eof;
    int          gap;
    bit          push;
    logic [31:0] exp_h;
    logic [31:0] exp_l;
    int          cnt;
    bit          last;
    bit          abort;
  } vec_t;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          cnt;
    bit          last;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [7:0] d, input bit sof, input bit eof,
                             input int gap, input bit push, input logic [31:0] eh,
                             input logic [31:0] el, input int cnt, input bit last,
                             input bit abort);
    vec_t r;
    r.d = d; r.sof = sof; r.eof = eof; r.gap = gap; r.push = push;
    r.exp_h = eh; r.exp_l = el; r.cnt = cnt; r.last = last; r.abort = abort;
    return r;
  endfunction

  function automatic vec_t w(input logic [7:0] d, input bit sof, input bit eof,
                             input int gap);
    return v(d, sof, eof, gap, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
  endfunction

  // Drive one word, then idle cycles with stray flags that must be ignored
  task automatic send(input vec_t x);
    exp_t e;
    if (x.push) begin
      e.h = x.exp_h; e.l = x.exp_l; e.cnt = x.cnt; e.last = x.last;
      sbq.push_back(e);
    end
    ser = x.d; ser_val = 1'b1; ser_sof = x.sof; ser_eof = x.eof;
    @(posedge clk); #1;
    chk($sformatf("abort_after_%h", x.d), {31'b0, abort_h}, {31'b0, x.abort});
    ser_val = 1'b0;
    for (int i = 0; i < x.gap; i++) begin
      ser_sof = 1'b1; ser_eof = 1'b1; ser = 8'h5C;
      @(posedge clk); #1;
    end
    ser_sof = 1'b0; ser_eof = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && val_h && par_rdy) begin
      if (sbq.size() == 0) begin
        chk("unexpected_block", par_h, 32'hxxxxxxxx);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("par_hi_order", par_h, e.h);
        chk("par_lo_order", par_l, e.l);
        chk("par_cnt", {29'b0, cnt_h}, e.cnt);
        chk("par_last", {31'b0, last_h}, {31'b0, e.last});
        chk("val_lo_order", {31'b0, val_l}, 32'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1; ser = '0; ser_val = 1'b0; ser_sof = 1'b0; ser_eof = 1'b0;
    par_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_par", par_h, 32'h0);
    chk("reset_cnt", {29'b0, cnt_h}, 32'h0);
    chk("reset_flags", {28'b0, val_h, last_h, ovf_h, abort_h}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    tbl.push_back(w(8'h11, 1, 0, 0));
    tbl.push_back(w(8'h22, 0, 0, 0));
    tbl.push_back(w(8'h33, 0, 0, 0));
    tbl.push_back(v(8'h44, 0, 1, 2, 1, 32'h11223344, 32'h44332211, 4, 1, 0));
    tbl.push_back(w(8'hAA, 1, 0, 0));
    tbl.push_back(w(8'hBB, 0, 0, 3));
    tbl.push_back(w(8'hCC, 0, 0, 0));
    tbl.push_back(v(8'hDD, 0, 0, 0, 1, 32'hAABBCCDD, 32'hDDCCBBAA, 4, 0, 0));
    tbl.push_back(w(8'hEE, 0, 0, 0));
    tbl.push_back(v(8'hFF, 0, 1, 1, 1, 32'hEEFF0000, 32'h0000FFEE, 2, 1, 0));
    tbl.push_back(w(8'h01, 1, 0, 0));
    tbl.push_back(w(8'h02, 0, 0, 0));
    tbl.push_back(v(8'h03, 0, 1, 1, 1, 32'h01020300, 32'h00030201, 3, 1, 0));
    tbl.push_back(v(8'h5A, 1, 1, 0, 1, 32'h5A000000, 32'h0000005A, 1, 1, 0));
    tbl.push_back(v(8'h6B, 1, 1, 1, 1, 32'h6B000000, 32'h0000006B, 1, 1, 0));
    tbl.push_back(w(8'h10, 1, 0, 0));
    tbl.push_back(w(8'h20, 0, 0, 0));
    tbl.push_back(v(8'h30, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1));
    tbl.push_back(w(8'h40, 0, 0, 0));
    tbl.push_back(w(8'h50, 0, 0, 0));
    tbl.push_back(v(8'h60, 0, 1, 1, 1, 32'h30405060, 32'h60504030, 4, 1, 0));
    tbl.push_back(w(8'h77, 1, 0, 0));
    tbl.push_back(v(8'h88, 1, 1, 1, 1, 32'h88000000, 32'h00000088, 1, 1, 1));

    foreach (tbl[i]) send(tbl[i]);
    repeat (2) @(posedge clk);
    #1;
    chk("ovf_clear_after_table", {31'b0, ovf_h}, 32'h0);

    // Output stalled: first block held, second dropped with sticky overflow
    par_rdy = 1'b0;
    send(w(8'hA1, 1, 0, 0));
    send(w(8'hA2, 0, 0, 0));
    send(w(8'hA3, 0, 0, 0));
    send(w(8'hA4, 0, 0, 0));
    chk("held_val", {31'b0, val_h}, 32'h1);
    chk("held_par", par_h, 32'hA1A2A3A4);
    send(w(8'hB1, 0, 0, 0));
    send(w(8'hB2, 0, 0, 0));
    send(w(8'hB3, 0, 0, 0));
    send(w(8'hB4, 0, 0, 2));
    chk("ovf_set", {31'b0, ovf_h}, 32'h1);
    chk("held_par_after_drop", par_h, 32'hA1A2A3A4);
    chk("held_cnt_after_drop", {29'b0, cnt_h}, 32'h4);
    chk("held_last_after_drop", {31'b0, last_h}, 32'h0);
    chk("held_val_after_drop", {31'b0, val_h}, 32'h1);
    e.h = 32'hA1A2A3A4; e.l = 32'hA4A3A2A1; e.cnt = 4; e.last = 1'b0;
    sbq.push_back(e);
    par_rdy = 1'b1;
    @(posedge clk); #1;
    chk("val_fall_on_accept", {31'b0, val_h}, 32'h0);
    chk("ovf_sticky", {31'b0, ovf_h}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ovf_cleared_by_rst", {31'b0, ovf_h}, 32'h0);
    chk("val_after_rst", {31'b0, val_h}, 32'h0);

    // Reset mid-block: partial words vanish, fresh block starts clean
    send(w(8'hC1, 1, 0, 0));
    send(w(8'hC2, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(w(8'hD1, 0, 0, 0));
    send(w(8'hD2, 0, 0, 0));
    send(w(8'hD3, 0, 0, 0));
    send(v(8'hD4, 0, 1, 2, 1, 32'hD1D2D3D4, 32'hD4D3D2D1, 4, 1, 0));
    chk("ovf_after_rst_seq", {31'b0, ovf_h}, 32'h0);
    chk("abort_after_rst_seq", {31'b0, abort_h}, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
